// File: rtl/dp_alu_pipe.sv
// Two-stage ARM data-processing pipe: register-shift barrel shifter, then 16-op ALU with NZCV.
// Valid/ready on both sides; stage 2 reads the live flags so back-to-back S ops chain correctly.
module dp_alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic               in_s,
    input  logic [1:0]         in_shift_type,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [WIDTH-1:0]   in_rn,
    input  logic [WIDTH-1:0]   in_rm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_wr,
    output logic [3:0]         out_flags,
    output logic [3:0]         flags_q,
    input  logic               flags_load,
    input  logic [3:0]         flags_val
);

    localparam int LW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_rn;
    logic [WIDTH-1:0] s1_op2;
    logic [3:0]       s1_op;
    logic             s1_s;
    logic             s1_sc;
    logic             s1_sc_pass;

    logic s2_adv;
    logic s1_load;
    logic s2_load;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_adv;

    // Shifter: an extra guard bit on each side captures the last bit shifted out,
    // which also yields the right carry for amounts equal to or beyond WIDTH.
    logic [WIDTH:0]     lsl_x;
    logic [WIDTH:0]     lsr_x;
    logic [WIDTH:0]     asr_x;
    logic [2*WIDTH-1:0] ror_x;
    logic [LW-1:0]      rot;
    logic [WIDTH-1:0]   sh_res;
    logic               sh_c;
    logic               sh_pass;

    always_comb begin
        lsl_x   = {1'b0, in_rm} << in_shamt;
        lsr_x   = {in_rm, 1'b0} >> in_shamt;
        asr_x   = $signed({in_rm, 1'b0}) >>> in_shamt;
        rot     = in_shamt[LW-1:0];
        ror_x   = {in_rm, in_rm} >> rot;
        sh_pass = (in_shamt == '0);
        sh_res  = in_rm;
        sh_c    = 1'b0;
        unique case (in_shift_type)
            2'd0:    {sh_c, sh_res} = lsl_x;
            2'd1:    {sh_res, sh_c} = lsr_x;
            2'd2:    {sh_res, sh_c} = asr_x;
            default: begin
                sh_res = ror_x[WIDTH-1:0];
                sh_c   = ror_x[WIDTH-1];
            end
        endcase
        if (sh_pass) sh_res = in_rm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_rn      <= '0;
            s1_op2     <= '0;
            s1_op      <= '0;
            s1_s       <= 1'b0;
            s1_sc      <= 1'b0;
            s1_sc_pass <= 1'b0;
        end else if (s1_load) begin
            s1_valid   <= 1'b1;
            s1_rn      <= in_rn;
            s1_op2     <= sh_res;
            s1_op      <= in_op;
            s1_s       <= in_s;
            s1_sc      <= sh_c;
            s1_sc_pass <= sh_pass;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    logic             c_in;
    logic             eff_c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             wr;
    logic [3:0]       nzcv;

    always_comb begin
        c_in  = flags_q[1];
        eff_c = s1_sc_pass ? c_in : s1_sc;
        a     = s1_rn;
        b     = s1_op2;
        cin   = 1'b0;
        arith = 1'b1;
        unique case (s1_op)
            OP_SUB, OP_CMP: begin
                b   = ~s1_op2;
                cin = 1'b1;
            end
            OP_RSB: begin
                a   = s1_op2;
                b   = ~s1_rn;
                cin = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                cin = 1'b0;
            end
            OP_ADC: cin = c_in;
            OP_SBC: begin
                b   = ~s1_op2;
                cin = c_in;
            end
            OP_RSC: begin
                a   = s1_op2;
                b   = ~s1_rn;
                cin = c_in;
            end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res = sum[WIDTH-1:0];
        unique case (s1_op)
            OP_AND, OP_TST: res = s1_rn & s1_op2;
            OP_EOR, OP_TEQ: res = s1_rn ^ s1_op2;
            OP_ORR:         res = s1_rn | s1_op2;
            OP_MOV:         res = s1_op2;
            OP_BIC:         res = s1_rn & ~s1_op2;
            OP_MVN:         res = ~s1_op2;
            default:        res = sum[WIDTH-1:0];
        endcase
        // TST/TEQ/CMP/CMN occupy opcodes 8..11
        wr      = (s1_op[3:2] != 2'b10);
        nzcv[3] = res[WIDTH-1];
        nzcv[2] = (res == '0);
        nzcv[1] = arith ? sum[WIDTH] : eff_c;
        nzcv[0] = arith ? ((a[WIDTH-1] == b[WIDTH-1]) &&
                           (sum[WIDTH-1] != a[WIDTH-1]))
                        : flags_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_wr     <= 1'b0;
            out_flags  <= '0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= res;
            out_wr     <= wr;
            out_flags  <= s1_s ? nzcv : flags_q;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (flags_load) begin
            flags_q <= flags_val;
        end else if (s2_load && s1_s) begin
            flags_q <= nzcv;
        end
    end

endmodule

// File: tb/tb_dp_alu_pipe.sv
// Directed bench for dp_alu_pipe: vector table for single ops, plus
// back-to-back flag chaining, a backpressured stream and mid-flight reset.
module tb_dp_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_s;
    logic [1:0]  in_shift_type;
    logic [7:0]  in_shamt;
    logic [31:0] in_rn;
    logic [31:0] in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_wr;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;
    logic        flags_load;
    logic [3:0]  flags_val;

    dp_alu_pipe #(.WIDTH(32), .SHAMT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_s(in_s),
        .in_shift_type(in_shift_type),
        .in_shamt(in_shamt),
        .in_rn(in_rn),
        .in_rm(in_rm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_wr(out_wr),
        .out_flags(out_flags),
        .flags_q(flags_q),
        .flags_load(flags_load),
        .flags_val(flags_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        s;
        logic [1:0]  st;
        logic [7:0]  sh;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  init;
        logic [31:0] res;
        logic        wr;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic s,
                       input logic [1:0] st, input logic [7:0] sh,
                       input logic [31:0] rn, input logic [31:0] rm,
                       input logic [3:0] init, input logic [31:0] res,
                       input logic wr, input logic [3:0] fl);
        vec_t v;
        v.op = op; v.s = s; v.st = st; v.sh = sh;
        v.rn = rn; v.rm = rm; v.init = init;
        v.res = res; v.wr = wr; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic s,
                         input logic [1:0] st, input logic [7:0] sh,
                         input logic [31:0] rn, input logic [31:0] rm);
        in_op = op; in_s = s; in_shift_type = st;
        in_shamt = sh; in_rn = rn; in_rm = rm;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        flags_load = 1'b1;
        flags_val  = v.init;
        in_valid   = 1'b0;
        @(negedge clk);
        flags_load = 1'b0;
        drive(v.op, v.s, v.st, v.sh, v.rn, v.rm);
        in_valid = 1'b1;
        #1;
        chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d early_valid", i), 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d result", i), out_result, v.res);
        chk($sformatf("vec%0d wr", i), 32'(out_wr), 32'(v.wr));
        chk($sformatf("vec%0d flags", i), 32'(out_flags), 32'(v.fl));
        chk($sformatf("vec%0d flags_q", i), 32'(flags_q),
            32'(v.s ? v.fl : v.init));
    endtask

    // Two ops on consecutive cycles, LSL #0, flags cleared first.
    task automatic pair(input string nm,
                        input logic [3:0] o1, input logic s1,
                        input logic [31:0] rn1, input logic [31:0] rm1,
                        input logic [31:0] r1, input logic [3:0] f1,
                        input logic [3:0] o2, input logic s2,
                        input logic [31:0] rn2, input logic [31:0] rm2,
                        input logic [31:0] r2, input logic wr2,
                        input logic [3:0] f2);
        @(negedge clk);
        flags_load = 1'b1;
        flags_val  = 4'h0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        flags_load = 1'b0;
        drive(o1, s1, 2'd0, 8'd0, rn1, rm1);
        in_valid = 1'b1;
        @(negedge clk);
        drive(o2, s2, 2'd0, 8'd0, rn2, rm2);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " op1 valid"}, 32'(out_valid), 32'd1);
        chk({nm, " op1 result"}, out_result, r1);
        chk({nm, " op1 flags"}, 32'(out_flags), 32'(f1));
        @(negedge clk);
        chk({nm, " op2 valid"}, 32'(out_valid), 32'd1);
        chk({nm, " op2 result"}, out_result, r2);
        chk({nm, " op2 wr"}, 32'(out_wr), 32'(wr2));
        chk({nm, " op2 flags"}, 32'(out_flags), 32'(f2));
        chk({nm, " flags_q"}, 32'(flags_q), 32'(f2));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[8];
        logic [31:0] held_res;
        logic        held_valid;
        int          sent;
        int          got;
        int          stalls;
        int          extra;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flags_load = 1'b0;
        flags_val = 4'h0;
        drive(4'd0, 1'b0, 2'd0, 8'd0, 32'd0, 32'd0);

        // op, s, st, sh, rn, rm, init, res, wr, flags
        add(4'd4,  1, 0, 0,  32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 1, 4'b0110);
        add(4'd13, 1, 0, 32, 32'h0, 32'h8000_0001, 4'b0000, 32'h0, 1, 4'b0110);
        add(4'd13, 1, 0, 33, 32'h0, 32'h8000_0001, 4'b0000, 32'h0, 1, 4'b0100);
        add(4'd13, 1, 2, 40, 32'h0, 32'h8000_0001, 4'b0000, 32'hFFFF_FFFF, 1, 4'b1010);
        add(4'd13, 1, 3, 32, 32'h0, 32'h8000_0001, 4'b0000, 32'h8000_0001, 1, 4'b1010);
        add(4'd13, 1, 1, 1,  32'h0, 32'h8000_0001, 4'b0000, 32'h4000_0000, 1, 4'b0010);
        add(4'd13, 1, 0, 0,  32'h0, 32'h5, 4'b0011, 32'h5, 1, 4'b0011);
        add(4'd2,  1, 0, 0,  32'h5, 32'h7, 4'b0000, 32'hFFFF_FFFE, 1, 4'b1000);
        add(4'd10, 1, 0, 0,  32'h7, 32'h7, 4'b0000, 32'h0, 0, 4'b0110);
        add(4'd3,  1, 0, 0,  32'h3, 32'hA, 4'b0000, 32'h7, 1, 4'b0010);
        add(4'd5,  0, 0, 0,  32'h0, 32'h0, 4'b0010, 32'h1, 1, 4'b0010);
        add(4'd6,  1, 0, 0,  32'hA, 32'h3, 4'b0000, 32'h6, 1, 4'b0010);
        add(4'd7,  1, 0, 0,  32'h3, 32'hA, 4'b0010, 32'h7, 1, 4'b0010);
        add(4'd4,  1, 0, 0,  32'h7FFF_FFFF, 32'h1, 4'b0000, 32'h8000_0000, 1, 4'b1001);
        add(4'd1,  1, 0, 4,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0001, 32'h0, 1, 4'b0101);
        add(4'd12, 1, 3, 8,  32'h00FF_0000, 32'h0000_FF00, 4'b0000, 32'h00FF_00FF, 1, 4'b0000);
        add(4'd14, 1, 0, 0,  32'hFFFF_FFFF, 32'h0000_FFFF, 4'b0000, 32'hFFFF_0000, 1, 4'b1000);
        add(4'd15, 1, 0, 0,  32'h0, 32'h0, 4'b0000, 32'hFFFF_FFFF, 1, 4'b1000);
        add(4'd8,  1, 0, 0,  32'hFF, 32'h100, 4'b0000, 32'h0, 0, 4'b0100);
        add(4'd9,  1, 0, 0,  32'hAA, 32'hAA, 4'b0011, 32'h0, 0, 4'b0111);
        add(4'd11, 1, 0, 0,  32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 0, 4'b0110);
        add(4'd13, 1, 2, 4,  32'h0, 32'h8000_0010, 4'b0000, 32'hF800_0001, 1, 4'b1000);
        add(4'd0,  1, 1, 32, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0000, 32'h0, 1, 4'b0110);
        add(4'd13, 1, 3, 4,  32'h0, 32'hF, 4'b0000, 32'hF000_0000, 1, 4'b1010);
        add(4'd2,  1, 0, 0,  32'h0, 32'h0, 4'b0000, 32'h0, 1, 4'b0110);
        add(4'd13, 1, 1, 33, 32'h0, 32'hFFFF_FFFF, 4'b0010, 32'h0, 1, 4'b0100);
        add(4'd13, 0, 0, 3,  32'h0, 32'h1, 4'b1111, 32'h8, 1, 4'b1111);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset flags_q", 32'(flags_q), 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_wr", 32'(out_wr), 32'd0);
        chk("reset out_flags", 32'(out_flags), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(i);

        pair("subs_cmp",
             4'd2, 1'b1, 32'h5, 32'h7, 32'hFFFF_FFFE, 4'b1000,
             4'd10, 1'b1, 32'h7, 32'h7, 32'h0, 1'b0, 4'b0110);
        pair("adds_adc_c0",
             4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001,
             4'd5, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0100);
        pair("adds_adc_c1",
             4'd4, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110,
             4'd5, 1'b0, 32'h0, 32'h0, 32'h1, 1'b1, 4'b0110);

        // Backpressured stream of ADDs
        for (int i = 0; i < 8; i++)
            exp_q[i] = 32'h1000 * i + 32'd7 + 32'd3 * i;
        sent = 0;
        got = 0;
        stalls = 0;
        held_valid = 1'b0;
        held_res = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            if (held_valid) begin
                chk("stream held valid", 32'(out_valid), 32'd1);
                chk("stream held result", out_result, held_res);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 8);
            drive(4'd4, 1'b0, 2'd0, 8'd0,
                  32'h1000 * sent + 32'd7, 32'd3 * sent);
            #1;
            if (out_valid && out_ready) begin
                if (got < 8)
                    chk($sformatf("stream result%0d", got),
                        out_result, exp_q[got]);
                got++;
            end
            held_valid = out_valid && !out_ready;
            held_res = out_result;
            if (held_valid) stalls++;
            if (in_valid && in_ready) sent++;
        end
        chk("stream count", 32'(got), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream no duplicate", 32'(extra), 32'd0);

        // Fill both stages, then reset under backpressure
        @(negedge clk);
        flags_load = 1'b1;
        flags_val = 4'b1111;
        @(negedge clk);
        flags_load = 1'b0;
        out_ready = 1'b0;
        drive(4'd4, 1'b1, 2'd0, 8'd0, 32'h11, 32'h22);
        in_valid = 1'b1;
        @(negedge clk);
        drive(4'd4, 1'b1, 2'd0, 8'd0, 32'h33, 32'h44);
        @(negedge clk);
        in_valid = 1'b0;
        chk("prefill s2 valid", 32'(out_valid), 32'd1);
        chk("prefill s1 full", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset flags_q", 32'(flags_q), 32'd0);
        chk("midreset out_result", out_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("midreset no stale output", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
